// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and constants for the HI/LO multiply/divide unit.
//   Op codes are the 3-bit i_op encoding seen by hilo_muldiv; DIV0_Q is the quotient
//   written to LO when the divisor is zero.
package muldiv_pkg;
   localparam int MD_DATA_W = 32;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [MD_DATA_W-1:0] DIV0_Q = '1;
   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: iterative radix-2 datapath on unsigned magnitudes, one step per i_step.
//   i_clk/i_reset : clock, sync active-high reset
//   i_load        : load i_a into the accumulator low half and latch divisor/multiplicand i_b
//   i_step        : perform one shift-add (multiply) or restoring shift-subtract (divide) step
//   i_div         : 1 = divide mode, 0 = multiply mode
//   o_hi/o_lo     : accumulator halves (product hi/lo, or remainder/quotient)
module muldiv_core #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic         i_step,
   input  logic         i_div,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_hi,
   output logic [W-1:0] o_lo
);
   logic [2*W-1:0] r_acc;
   logic [W-1:0]   r_b;
   logic [W:0]     w_sum;
   logic [W:0]     w_rsh;
   logic [W-1:0]   w_diff;
   logic           w_ge;
   always_comb begin
      w_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_b : {W{1'b0}})};
      // shifted partial remainder can reach W+1 bits; the difference always fits W bits when taken
      w_rsh  = {r_acc[2*W-1:W], r_acc[W-1]};
      w_ge   = w_rsh >= {1'b0, r_b};
      w_diff = w_rsh[W-1:0] - r_b;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_acc <= '0;
         r_b   <= '0;
      end else if (i_load) begin
         r_acc <= {{W{1'b0}}, i_a};
         r_b   <= i_b;
      end else if (i_step) begin
         r_acc <= i_div ? {(w_ge ? w_diff : w_rsh[W-1:0]), r_acc[W-2:0], w_ge}
                        : {w_sum, r_acc[W-1:1]};
      end
   end
   assign o_hi = r_acc[2*W-1:W];
   assign o_lo = r_acc[W-1:0];
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: MIPS HI/LO multiply/divide unit with busy/done handshake.
//   i_clk/i_reset      : clock, sync active-high reset
//   i_start, i_op      : request and op code (MULT/MULTU/DIV/DIVU/MTHI/MTLO), sampled when idle
//   i_rs_data/i_rt_data: operands (dividend/divisor); MTHI/MTLO source is i_rs_data
//   o_busy             : multi-cycle operation in flight
//   o_done             : one-cycle pulse after HI/LO written by a mult/div
//   o_hi/o_lo          : architectural HI/LO registers
module hilo_muldiv
   import muldiv_pkg::*;
#(
   parameter int DATA_W = MD_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [2:0]        i_op,
   input  logic [DATA_W-1:0] i_rs_data,
   input  logic [DATA_W-1:0] i_rt_data,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);
   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
   state_t              r_state, w_next;
   logic [CW-1:0]       r_cnt;
   logic                r_is_div, r_neg_q, r_neg_r, r_div0, r_done;
   logic [DATA_W-1:0]   r_rs, r_hi, r_lo;
   logic                w_accept, w_load, w_step, w_signed;
   logic [DATA_W-1:0]   w_a, w_b, w_core_hi, w_core_lo, w_fix_hi, w_fix_lo;
   logic [2*DATA_W-1:0] w_prod;
   always_comb begin
      w_accept = (r_state == ST_IDLE) && i_start;
      w_load   = w_accept && !i_op[2];
      w_step   = r_state == ST_CALC;
      w_next   = (r_state == ST_IDLE) ? (w_load ? ST_CALC : ST_IDLE) :
                 (r_state == ST_CALC) ? ((r_cnt == LAST) ? ST_FIX : ST_CALC) : ST_IDLE;
   end
   // MULT and DIV (op bit 0 clear) are signed; the core only ever sees magnitudes
   always_comb begin
      w_signed = !i_op[0];
      w_a      = (w_signed && i_rs_data[DATA_W-1]) ? -i_rs_data : i_rs_data;
      w_b      = (w_signed && i_rt_data[DATA_W-1]) ? -i_rt_data : i_rt_data;
      w_prod   = r_neg_q ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
      w_fix_hi = r_is_div ? (r_div0 ? r_rs : (r_neg_r ? -w_core_hi : w_core_hi)) : w_prod[2*DATA_W-1:DATA_W];
      w_fix_lo = r_is_div ? (r_div0 ? DIV0_Q : (r_neg_q ? -w_core_lo : w_core_lo)) : w_prod[DATA_W-1:0];
   end
   muldiv_core #(.W(DATA_W)) u_core (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_div   (r_is_div),
      .i_a     (w_a),
      .i_b     (w_b),
      .o_hi    (w_core_hi),
      .o_lo    (w_core_lo)
   );
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_rs     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= r_state == ST_FIX;
         r_cnt   <= w_step ? r_cnt + 1'b1 : '0;
         if (w_load) begin
            r_is_div <= i_op[1];
            r_neg_q  <= w_signed && (i_rs_data[DATA_W-1] ^ i_rt_data[DATA_W-1]);
            r_neg_r  <= w_signed && i_rs_data[DATA_W-1];
            r_div0   <= i_op[1] && (i_rt_data == '0);
            r_rs     <= i_rs_data;
         end
         if (w_accept && i_op == OP_MTHI) r_hi <= i_rs_data;
         if (w_accept && i_op == OP_MTLO) r_lo <= i_rs_data;
         if (r_state == ST_FIX) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
         end
      end
   end
   assign o_busy = r_state != ST_IDLE;
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS-32 core. Takes the two operands read from the register file (rs, rt) and executes MULT, MULTU, DIV and DIVU over multiple cycles, or MTHI and MTLO in a single cycle. HI/LO feed the MFHI/MFLO write-back path into the register file. A busy/done handshake lets the control unit stall the pipeline.

## Interface
- DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  request; sampled only when busy=0
- op  in  3  operation code (muldiv_pkg): 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- rs_data  in  DATA_W  operand A / dividend / MTHI-MTLO source
- rt_data  in  DATA_W  operand B / divisor
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse: HI/LO updated by MULT/MULTU/DIV/DIVU
- hi  out  DATA_W  HI register (product upper half / remainder)
- lo  out  DATA_W  LO register (product lower half / quotient)

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE with start=1:
  - Mult/div op: latch operands, capture sign flags, convert signed operands to magnitude, clear iteration counter, go to CALC.
  - MTHI/MTLO: write rs_data to hi/lo at that edge, stay IDLE, no busy, no done.
  - No-op codes: ignored.
- CALC: one radix-2 step per cycle for DATA_W cycles, counter 0..DATA_W-1, then FIX.
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder magnitudes.
- FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient negative if signs differ; remainder takes the dividend's sign.
- Arithmetic rules:
  - Magnitude of 0x80000000 is treated as unsigned 0x80000000.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
  - Divide by zero (DIV or DIVU, rt_data=0): detected at accept; full latency still taken; result lo=0xFFFFFFFF, hi=rs_data (original, unsigned view).
- start while busy: ignored, including MTHI/MTLO. No queueing.
- hi/lo hold their value except on FIX, MTHI/MTLO, or reset.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state IDLE, counter 0.
- Accept edge E0. busy=1 from E0 through E0+DATA_W+1.
- CALC occupies edges E1..E32. FIX occupies edge E33, where hi/lo are written.
- After E33: busy=0 and done=1 for exactly one cycle. Results visible 33 cycles after accept.
- The first cycle with busy=0 and done=1 may accept a new start (back-to-back allowed).
- MTHI/MTLO: hi/lo visible the cycle after the accept edge.
- Reset asserted mid-operation: next edge returns to IDLE and zeros hi/lo. No done pulse; the partial result is discarded.
- Operands are sampled only at accept. rs_data/rt_data may change during CALC without effect.

## Structure
- muldiv_pkg holds:
  - op code localparams and FSM state enum
  - DATA_W default
  - divide-by-zero quotient constant (all ones)
- muldiv_core is the one natural sub-module. It contains the iterative accumulator/remainder datapath, driven by the top-level FSM with mode (mul/div) and step enables.
- Top-level hilo_muldiv owns the FSM, counter, sign handling, and HI/LO registers.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Separately, DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=0x64, rt=0 -> lo=0xFFFFFFFF, hi=0x64, same latency.
- MTHI 0x12345678 while idle -> hi=0x12345678 next cycle, busy never asserted.
- MTLO 0x1 or MULT pulsed at cycle 10 of a DIVU -> ignored. DIVU result is unaffected, and lo is not overwritten with 0x1.
- Reset asserted at cycle 15 of a MULT -> next cycle busy=0, done=0, hi=lo=0. A new MULTU 6x7 then yields lo=0x2A, hi=0.
